// File: rtl/regfile_sb.sv
// Parametrised integer register file with same-cycle write bypass and a
// per-register pending-write scoreboard used by issue to stall dependents.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int RPORTS = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RPORTS-1:0]      rd_req,
  input  logic [RPORTS*AW-1:0]   rd_addr,
  output logic [RPORTS*XLEN-1:0] rd_data,
  output logic [RPORTS-1:0]      rd_busy,
  output logic                   stall,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  input  logic                   flush,
  output logic [AW:0]            busy_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [AW:0]     cnt_next;

  // Issue is applied after writeback so the newest producer keeps ownership.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (wr_en && (wr_addr != '0)) busy_next[wr_addr] = 1'b0;
      if (iss_en && (iss_addr != '0)) busy_next[iss_addr] = 1'b1;
    end
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_next = cnt_next + {{AW{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_en && (wr_addr != '0)) regs[wr_addr] <= wr_data;
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

  // A writeback in flight both forwards its data and releases the reader.
  for (genvar p = 0; p < RPORTS; p++) begin : g_port
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = rd_addr[p*AW +: AW];
    assign hit  = wr_en && (wr_addr == addr);

    assign rd_data[p*XLEN +: XLEN] = (hit && (addr != '0)) ? wr_data :
                                     (addr == '0)          ? '0      :
                                                             regs[addr];
    assign rd_busy[p] = busy[addr] & ~hit;
  end

  assign stall = |(rd_req & rd_busy);

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed checks of regfile_sb against a behavioural model,
// plus a second instance with a wider, shallower, three-port configuration.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  rd_req = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        stall;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic        flush = 1'b0;
  logic [5:0]  busy_cnt;

  logic         b_rst = 1'b0;
  logic [2:0]   b_rd_req = '0;
  logic [11:0]  b_rd_addr = '0;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic         b_stall;
  logic         b_wr_en = 1'b0;
  logic [3:0]   b_wr_addr = '0;
  logic [63:0]  b_wr_data = '0;
  logic         b_iss_en = 1'b0;
  logic [3:0]   b_iss_addr = '0;
  logic         b_flush = 1'b0;
  logic [4:0]   b_busy_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_reg  [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .stall(stall),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt)
  );

  regfile_sb #(.XLEN(64), .NREG(16), .RPORTS(3)) dut_b (
    .clk(clk), .rst(b_rst), .rd_req(b_rd_req), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_busy(b_rd_busy), .stall(b_stall),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .iss_en(b_iss_en), .iss_addr(b_iss_addr), .flush(b_flush), .busy_cnt(b_busy_cnt)
  );

  // Behavioural reference: what a reader sees, and what an edge does.
  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (wr_en && wr_addr == a && a != 0) return wr_data;
    if (a == 0) return 32'h0;
    return m_reg[a];
  endfunction

  function automatic bit exp_busy(input logic [4:0] a);
    return m_busy[a] && !(wr_en && wr_addr == a);
  endfunction

  function automatic int exp_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) m_reg[wr_addr] = wr_data;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
        if (wr_en && wr_addr != 0) m_busy[wr_addr] = 1'b0;
        if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; wr_en = 0; iss_en = 0; rd_req = '0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 20; c++) begin
      wr_en = 1'($urandom); wr_addr = 5'($urandom); wr_data = $urandom;
      iss_en = 1'($urandom); iss_addr = 5'($urandom);
      tick();
    end
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #2;
    checks++;
    if (busy_cnt !== 6'd0) begin
      errors++; $display("[TB] FAIL reset_busy_cnt got=%0d exp=0", busy_cnt);
    end
    rd_req = 2'b11;
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31 - i), 5'(i)};
      #1;
      checks++;
      if (rd_data !== 64'h0 || rd_busy !== 2'b00 || stall !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_read addr=%0d got data=%h busy=%b stall=%b exp 0/00/0",
                 i, rd_data, rd_busy, stall);
      end
    end
    idle_inputs();
  endtask

  task automatic test_bypass_x0();
    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    rd_addr = {5'd5, 5'd5};
    #2;
    checks++;
    if (rd_data !== {2{32'hDEADBEEF}}) begin
      errors++; $display("[TB] FAIL bypass_same_cycle got=%h exp=%h", rd_data, {2{32'hDEADBEEF}});
    end
    tick();
    wr_en = 0;
    #2;
    checks++;
    if (rd_data !== {2{32'hDEADBEEF}}) begin
      errors++; $display("[TB] FAIL stored_next_cycle got=%h exp=%h", rd_data, {2{32'hDEADBEEF}});
    end
    wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
    rd_addr = '0;
    #2;
    checks++;
    if (rd_data !== 64'h0) begin
      errors++; $display("[TB] FAIL x0_bypass got=%h exp=0", rd_data);
    end
    tick();
    wr_en = 0;
    #2;
    checks++;
    if (rd_data !== 64'h0) begin
      errors++; $display("[TB] FAIL x0_stored got=%h exp=0", rd_data);
    end
  endtask

  task automatic test_scoreboard();
    iss_en = 1; iss_addr = 7;
    rd_req = 2'b01; rd_addr = {5'd0, 5'd7};
    #2;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("[TB] FAIL sb_cycle0_stall got=%b exp=0", stall);
    end
    tick();
    iss_en = 0;
    for (int c = 1; c <= 3; c++) begin
      #2;
      checks++;
      if (stall !== 1'b1 || busy_cnt !== 6'd1) begin
        errors++; $display("[TB] FAIL sb_cycle%0d got stall=%b cnt=%0d exp 1/1", c, stall, busy_cnt);
      end
      tick();
    end
    wr_en = 1; wr_addr = 7; wr_data = 32'hA5;
    #2;
    checks++;
    if (stall !== 1'b0 || rd_data[31:0] !== 32'hA5) begin
      errors++; $display("[TB] FAIL sb_release got stall=%b data=%h exp 0/a5", stall, rd_data[31:0]);
    end
    tick();
    wr_en = 0;
    #2;
    checks++;
    if (busy_cnt !== 6'd0) begin
      errors++; $display("[TB] FAIL sb_cnt_after_write got=%0d exp=0", busy_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    iss_en = 1; iss_addr = 9;
    tick();
    wr_en = 1; wr_addr = 9; wr_data = 32'h0BADF00D;
    tick();
    idle_inputs();
    rd_addr = {5'd9, 5'd9};
    #2;
    checks++;
    if (busy_cnt !== 6'd1 || rd_busy !== 2'b11 || rd_data !== {2{32'h0BADF00D}}) begin
      errors++;
      $display("[TB] FAIL simultaneous got cnt=%0d busy=%b data=%h exp 1/11/%h",
               busy_cnt, rd_busy, rd_data, {2{32'h0BADF00D}});
    end
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 3; r++) begin
      iss_en = 1; iss_addr = 5'(r);
      tick();
    end
    flush = 1; iss_en = 1; iss_addr = 4;
    tick();
    idle_inputs();
    rd_addr = {5'd4, 5'd1};
    rd_req = 2'b11;
    #2;
    checks++;
    if (busy_cnt !== 6'd0 || rd_busy !== 2'b00 || stall !== 1'b0) begin
      errors++; $display("[TB] FAIL flush got cnt=%0d busy=%b stall=%b exp 0/00/0", busy_cnt, rd_busy, stall);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 24) == 0);
      wr_en = 1'($urandom); wr_addr = 5'($urandom); wr_data = $urandom;
      iss_en = 1'($urandom); iss_addr = 5'($urandom);
      rd_req = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        rd_addr[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
      end
      #2;
      begin
        logic [1:0] eb;
        for (int p = 0; p < 2; p++) begin
          logic [4:0] a;
          a = rd_addr[p*5 +: 5];
          eb[p] = exp_busy(a);
          checks++;
          if (rd_data[p*32 +: 32] !== exp_data(a) || rd_busy[p] !== eb[p]) begin
            errors++;
            $display("[TB] FAIL rand_read cyc=%0d port=%0d addr=%0d got data=%h busy=%b exp %h/%b",
                     c, p, a, rd_data[p*32 +: 32], rd_busy[p], exp_data(a), eb[p]);
          end
        end
        checks++;
        if (stall !== |(rd_req & eb)) begin
          errors++; $display("[TB] FAIL rand_stall cyc=%0d got=%b exp=%b", c, stall, |(rd_req & eb));
        end
      end
      tick();
      checks++;
      if (int'(busy_cnt) != exp_count()) begin
        errors++; $display("[TB] FAIL rand_busy_cnt cyc=%0d got=%0d exp=%0d", c, busy_cnt, exp_count());
      end
    end
    idle_inputs();
  endtask

  task automatic test_param_sweep();
    b_rst = 1;
    @(posedge clk); #1;
    b_rst = 0;
    for (int r = 1; r <= 15; r++) begin
      b_iss_en = 1; b_iss_addr = 4'(r);
      @(posedge clk); #1;
    end
    b_iss_addr = 0;
    @(posedge clk); #1;
    b_iss_en = 0;
    b_rd_addr = '0;
    b_rd_req = 3'b111;
    #2;
    checks++;
    if (b_busy_cnt !== 5'd15 || b_rd_busy !== 3'b000) begin
      errors++; $display("[TB] FAIL sweep_cnt got cnt=%0d x0busy=%b exp 15/000", b_busy_cnt, b_rd_busy);
    end
    b_wr_en = 1; b_wr_addr = 12; b_wr_data = 64'hFEEDFACE_01234567;
    b_rd_addr = {4'd0, 4'd12, 4'd12};
    #2;
    checks++;
    if (b_rd_data !== {64'h0, 64'hFEEDFACE_01234567, 64'hFEEDFACE_01234567} ||
        b_rd_busy !== 3'b000 || b_stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sweep_bypass got data=%h busy=%b stall=%b", b_rd_data, b_rd_busy, b_stall);
    end
    @(posedge clk); #1;
    b_wr_en = 0;
    b_rd_addr = {4'd5, 4'd12, 4'd3};
    #2;
    checks++;
    if (b_rd_busy !== 3'b101 || b_stall !== 1'b1 || b_busy_cnt !== 5'd14 ||
        b_rd_data[127:64] !== 64'hFEEDFACE_01234567) begin
      errors++;
      $display("[TB] FAIL sweep_after got busy=%b stall=%b cnt=%0d data1=%h exp 101/1/14/feedface01234567",
               b_rd_busy, b_stall, b_busy_cnt, b_rd_data[127:64]);
    end
    b_rd_req = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 1'b0;
    end
    rst = 1;
    tick();
    tick();
    rst = 0;
    test_reset();
    test_bypass_x0();
    test_scoreboard();
    test_simultaneous();
    test_flush();
    test_random();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
